// File: rtl/booth_mac_pkg.sv
// Shared definitions for the radix-4 Booth multiply-accumulate pipeline:
// digit encodings, partial-product count and default accumulator width.
package booth_mac_pkg;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_digit_e;

  function automatic int pp_count(input int data_w);
    return data_w / 2 + 1;
  endfunction

  function automatic int acc_w_default(input int data_w);
    return 2 * data_w + 8;
  endfunction

  // Code is {b[2i+1], b[2i], b[2i-1]} of the extended multiplier.
  function automatic booth_digit_e booth_decode(input logic [2:0] code);
    booth_digit_e d;
    case (code)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: selects 0, +-A or +-2A; negatives are
// returned one's-complemented with neg=1 so the +1 joins the compression tree.
module booth_pp_gen
  import booth_mac_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W+1:0] a_ext,
  input  logic        [2:0]        code,
  output logic        [DATA_W+2:0] pp,
  output logic                     neg
);

  logic signed [DATA_W+2:0] a1;
  logic signed [DATA_W+2:0] a2;

  assign a1 = (DATA_W+3)'(a_ext);
  assign a2 = a1 <<< 1;

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (booth_decode(code))
      BD_POS1: pp = a1;
      BD_POS2: pp = a2;
      BD_NEG1: begin
        pp  = ~a1;
        neg = 1'b1;
      end
      BD_NEG2: begin
        pp  = ~a2;
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mac_pipe.sv
// Pipelined radix-4 Booth multiply-accumulate with sticky overflow and a
// valid/ready output register; a single enable stalls every stage together.
module booth_mac_pipe
  import booth_mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_w_default(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              in_signed,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  localparam int N      = pp_count(DATA_W);
  localparam int PP_W   = DATA_W + 3;
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam int R      = N + 1;
  localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

  function automatic logic add_ovf_signed(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y,
                                          input logic [ACC_W-1:0] s);
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !rst;

  logic signed [DATA_W+1:0] a_ext;
  logic signed [DATA_W+1:0] b_ext;
  logic        [DATA_W+2:0] b_pad;
  logic        [PP_W-1:0]   pp_d [N];
  logic        [N-1:0]      neg_d;

  assign a_ext = {{2{in_signed & op_a[DATA_W-1]}}, op_a};
  assign b_ext = {{2{in_signed & op_b[DATA_W-1]}}, op_b};
  assign b_pad = {b_ext, 1'b0};

  for (genvar i = 0; i < N; i++) begin : g_pp
    booth_pp_gen #(.DATA_W(DATA_W)) u_pp (
      .a_ext (a_ext),
      .code  (b_pad[2*i +: 3]),
      .pp    (pp_d[i]),
      .neg   (neg_d[i])
    );
  end

  // ---- S1: Booth partial products and negate bits ----
  logic [PP_W-1:0] pp_p0 [N];
  logic [N-1:0]    neg_p0;
  logic            vld_p0, first_p0, last_p0, sgn_p0;

  logic [PROD_W-1:0] row [R];

  always_comb begin
    for (int i = 0; i < N; i++) row[i] = PROD_W'(signed'(pp_p0[i])) << (2 * i);
    row[N] = '0;
    for (int i = 0; i < N; i++) row[N][2*i] = neg_p0[i];
  end

  // Linear carry-save chain: half adders merge rows 0/1, then one full-adder
  // row per remaining partial product; carries beyond PROD_W wrap away.
  for (genvar k = 1; k < R; k++) begin : g_lvl
    logic [PROD_W-1:0] x, y, s, c;
    if (k == 1) begin : g_src0
      assign x = row[0];
      assign y = row[1];
    end else begin : g_srck
      assign x = g_lvl[k-1].s;
      assign y = g_lvl[k-1].c;
    end
    assign c[0] = 1'b0;
    for (genvar j = 0; j < PROD_W; j++) begin : g_bit
      if (k == 1) begin : g_ha
        assign s[j] = x[j] ^ y[j];
        if (j < PROD_W - 1) begin : g_cy
          assign c[j+1] = x[j] & y[j];
        end
      end else begin : g_fa
        assign s[j] = x[j] ^ y[j] ^ row[k][j];
        if (j < PROD_W - 1) begin : g_cy
          assign c[j+1] = (x[j] & y[j]) | (row[k][j] & (x[j] ^ y[j]));
        end
      end
    end
  end

  logic [PROD_W-1:0] csa_s, csa_c;
  assign csa_s = g_lvl[R-1].s;
  assign csa_c = g_lvl[R-1].c;

  // ---- S2: two carry-save vectors ----
  logic [PROD_W-1:0] sum_p1, carry_p1;
  logic              vld_p1, first_p1, last_p1, sgn_p1;

  logic [PROD_W-1:0] prod;
  logic [EXT_W-1:0]  prod_wide;
  logic [ACC_W-1:0]  prod_ext, base, acc_nxt;
  logic              acc_cout, ovf_beat, ovf_nxt;

  assign prod      = sum_p1 + carry_p1;
  assign prod_wide = EXT_W'(signed'(prod));
  assign prod_ext  = prod_wide[ACC_W-1:0];

  // ---- S3: accumulator and sticky overflow ----
  logic [ACC_W-1:0] acc_p2;
  logic             ovf_p2, vld_p2, last_p2;

  assign base                = first_p1 ? '0 : acc_p2;
  assign {acc_cout, acc_nxt} = {1'b0, base} + {1'b0, prod_ext};
  assign ovf_beat            = sgn_p1 ? add_ovf_signed(base, prod_ext, acc_nxt) : acc_cout;
  assign ovf_nxt             = first_p1 ? ovf_beat : (ovf_p2 | ovf_beat);

  always_ff @(posedge clk) begin
    if (en) begin
      pp_p0    <= pp_d;
      neg_p0   <= neg_d;
      first_p0 <= in_first;
      last_p0  <= in_last;
      sgn_p0   <= in_signed;
      sum_p1   <= csa_s;
      carry_p1 <= csa_c;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      sgn_p1   <= sgn_p0;
      last_p2  <= last_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      acc_p2    <= '0;
      ovf_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        acc_p2 <= acc_nxt;
        ovf_p2 <= ovf_nxt;
      end
      // ---- output register ----
      out_valid <= vld_p2 && last_p2;
      if (vld_p2 && last_p2) begin
        out_acc <= acc_p2;
        out_ovf <= ovf_p2;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_pipe.sv
// Scoreboard bench for booth_mac_pipe: one DATA_W=8/ACC_W=24 instance and one
// ACC_W=16 instance, fed directed beats with hand-computed results.
module tb_booth_mac_pipe;

  typedef struct packed {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_signed, in_first, in_last;
  logic [7:0]  op_a, op_b;
  logic        out_ready;
  logic        sel;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ovf_a;
  logic [23:0] out_acc_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ovf_b;
  logic [15:0] out_acc_b;
  logic        in_ready;

  exp_t q24[$];
  exp_t q16[$];
  int   tests  = 0;
  int   failed = 0;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign in_ready   = sel ? in_ready_b : in_ready_a;

  booth_mac_pipe #(.DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op_a(op_a), .op_b(op_b), .in_signed(in_signed), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_ovf(out_ovf_a)
  );

  booth_mac_pipe #(.DATA_W(8), .ACC_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op_a(op_a), .op_b(op_b), .in_signed(in_signed), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] req);
    tests++;
    if (got !== req) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_ready) begin
      if (out_valid_a) begin
        if (q24.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_a: got %h required no output", out_acc_a);
        end else begin
          e = q24.pop_front();
          chk("acc24", out_acc_a, e.acc);
          chk("ovf24", {23'd0, out_ovf_a}, {23'd0, e.ovf});
        end
      end
      if (out_valid_b) begin
        if (q16.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_b: got %h required no output", out_acc_b);
        end else begin
          e = q16.pop_front();
          chk("acc16", {8'd0, out_acc_b}, e.acc);
          chk("ovf16", {23'd0, out_ovf_b}, {23'd0, e.ovf});
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      input logic f, input logic l);
    logic rdy;
    int   g;
    in_valid = 1'b1; op_a = a; op_b = b; in_signed = sg; in_first = f; in_last = l;
    rdy = 1'b0;
    g = 0;
    while (!rdy && g < 100) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (!rdy) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 100 cycles");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q24.size() != 0 || q16.size() != 0) && g < 60) begin
      @(posedge clk);
      g++;
    end
    chk("drain_pending", 24'(q24.size() + q16.size()), 24'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [23:0] sq [6] = '{24'd1, 24'd4, 24'd9, 24'd16, 24'd25, 24'd36};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0;
    op_a = '0; op_b = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {23'd0, in_ready_a}, 24'd0);
    chk("rst_out_valid", {23'd0, out_valid_a}, 24'd0);
    chk("rst_out_acc", out_acc_a, 24'd0);
    chk("rst_out_ovf", {23'd0, out_ovf_a}, 24'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {23'd0, in_ready_a}, 24'd1);
    @(posedge clk);
    #1;

    // signed 0x80 x 0x80 with latency probe
    send(8'h80, 8'h80, 1'b1, 1'b1, 1'b1);
    q24.push_back('{acc: 24'h004000, ovf: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("lat_t2_out_valid", {23'd0, out_valid_a}, 24'd0);
    @(posedge clk);
    #1;
    chk("lat_t3_out_valid", {23'd0, out_valid_a}, 24'd1);
    drain();

    // unsigned 0xFF x 0xFF
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    q24.push_back('{acc: 24'h00FE01, ovf: 1'b0});
    drain();

    // signed dot product -> -39
    send(8'h03, 8'hFB, 1'b1, 1'b1, 1'b0);
    send(8'h07, 8'h07, 1'b1, 1'b0, 1'b0);
    send(8'hFE, 8'h64, 1'b1, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b1, 1'b0, 1'b1);
    q24.push_back('{acc: 24'hFFFFD9, ovf: 1'b0});
    drain();

    // backpressure: six back-to-back single-beat products
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send(8'(k), 8'(k), 1'b1, 1'b1, 1'b1);
          q24.push_back('{acc: sq[k-1], ovf: 1'b0});
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_in_ready", {23'd0, in_ready_a}, 24'd0);
        chk("bp_out_valid", {23'd0, out_valid_a}, 24'd1);
        chk("bp_out_acc_hold", out_acc_a, 24'd1);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // ACC_W=16 sticky overflow, then reload on next first beat
    sel = 1'b1;
    send(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    q16.push_back('{acc: 24'h00C000, ovf: 1'b1});
    send(8'h01, 8'h01, 1'b1, 1'b1, 1'b1);
    q16.push_back('{acc: 24'h000001, ovf: 1'b0});
    drain();
    sel = 1'b0;

    // reset with two accumulating beats in flight
    send(8'h05, 8'h05, 1'b1, 1'b1, 1'b0);
    send(8'h03, 8'h03, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_acc", out_acc_a, 24'd0);
    chk("midrst_out_valid", {23'd0, out_valid_a}, 24'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h02, 8'h03, 1'b1, 1'b1, 1'b1);
    q24.push_back('{acc: 24'd6, ovf: 1'b0});
    drain();

    // beat without in_first right after reset accumulates onto zero
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'h02, 8'h05, 1'b1, 1'b0, 1'b1);
    q24.push_back('{acc: 24'd10, ovf: 1'b0});
    drain();

    chk("final_q24_empty", 24'(q24.size()), 24'd0);
    chk("final_q16_empty", 24'(q16.size()), 24'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule
